tuple_field_serializer: RTL
===========================

// Module: tuple_field_serializer
// PURPOSE
//  Receive end of the two-field tuple output (O__0, O__1) produced by generated comb/top modules.
//  Accepts whole tuples on a valid/ready port and buffers them in a DEPTH-entry FIFO.
//  Emits each tuple as two ordered field beats (field 0, then field 1) on a narrow valid/ready
//  stream, so downstream logic consumes one field per transfer.
// PARAMETERS
//  WIDTH  1  bit width of each tuple field (I__0, I__1, O_data)
//  DEPTH  2  input FIFO entries; power of two, >= 2
// PORTS
//  CLK          in   1      sole clock; all state updates on rising edge
//  ASYNCRESETN  in   1      asynchronous, active-low reset
//  I__0         in   WIDTH  tuple field 0
//  I__1         in   WIDTH  tuple field 1
//  I_valid      in   1      tuple on I__0/I__1 is valid
//  I_ready      out  1      FIFO can accept a tuple
//  O_data       out  WIDTH  current field value
//  O_idx        out  1      index of current field (0 or 1)
//  O_last       out  1      high on the field-1 beat
//  O_valid      out  1      field beat valid
//  O_ready      in   1      downstream accepts beat
//  O_count      out  16     tuples fully emitted (only with TUPLE_SER_COUNT_EN)
// BEHAVIOUR
//  Reset (ASYNCRESETN low, effective immediately):
//   - FIFO empty; FSM in IDLE
//   - I_ready=0, O_valid=0, O_data=0, O_idx=0, O_last=0, O_count=0
//   - I_ready rises in the first cycle after release
//  Input handshake:
//   - Push {I__1,I__0} at the edge where I_valid&&I_ready.
//   - I_ready = !full, decoded from registered occupancy only; no combinational path from O_ready.
//   - A full FIFO refuses input even in a cycle where it is popped.
//  FSM states: IDLE, F0, F1; hold register HOLD = {h1,h0}
//   - IDLE: if FIFO non-empty, pop into HOLD -> F0; else stay.
//   - F0: O_valid=1, O_data=h0, O_idx=0, O_last=0; on O_ready -> F1.
//   - F1: O_valid=1, O_data=h1, O_idx=1, O_last=1; on O_ready:
//       FIFO non-empty -> pop into HOLD -> F0 (back-to-back, no bubble); else -> IDLE.
//   - O_data/O_idx/O_last are registered; held stable while O_valid && !O_ready.
//  Latency and throughput:
//   - Tuple pushed into an empty, idle block at edge t: field 0 is valid from edge t+1.
//   - With O_ready held high: one tuple per 2 cycles.
//   - Full throughput is sustained when I_valid is asserted at most every 2nd cycle.
//  Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
//   - Occupancy counter is log2(DEPTH)+1 bits.
//   - Push and pop in the same cycle leave occupancy unchanged.
//  Boundaries:
//   - Empty FIFO in F1 on acceptance -> IDLE, O_valid=0 next cycle.
//   - Field 1 is never emitted without field 0 of the same tuple.
//   - Reset mid-tuple (F0 or F1) discards HOLD and FIFO contents; no orphan field-1 beat follows reset.
//   - O_ready asserted while O_valid=0 has no effect.
// CONFIGURATION
//  TUPLE_SER_COUNT_EN defined:
//   - O_count port present.
//   - Increments by 1 on each F1 beat accepted (O_valid&&O_ready&&O_last).
//   - Wraps 16'hFFFF -> 16'h0000; reset to 0.
//  TUPLE_SER_COUNT_EN undefined:
//   - O_count port and counter absent; all other behaviour identical.
// TESTING (WIDTH=8, DEPTH=2, O_ready=1 unless stated)
//  1. Reset then push (I__0=8'hA5, I__1=8'h3C).
//     -> Beat 1: O_data=A5, O_idx=0, O_last=0. Beat 2: O_data=3C, O_idx=1, O_last=1.
//     -> Then O_valid=0.
//  2. O_ready=0, push 3 tuples back-to-back.
//     -> First 2 accepted and 1 loaded into HOLD; I_ready=0 once FIFO full.
//     -> Release O_ready: 6 beats in push order, no bubble between tuples.
//  3. Stall O_ready=0 for 5 cycles during F0 (O_data=8'h11).
//     -> O_valid, O_data=11, O_idx=0 stable every stalled cycle.
//  4. Assert ASYNCRESETN low mid-cycle during F1.
//     -> O_valid=0, I_ready=0 immediately.
//     -> After release, no beat until a new tuple is pushed.
//  5. TUPLE_SER_COUNT_EN: preload 65535 completed tuples (force or run), send 1 more.
//     -> O_count goes 16'hFFFF -> 16'h0000.
//     -> Without the macro, the build has no O_count port.
//  6. Random I_valid/O_ready, 10k tuples.
//     -> Scoreboard: beats strictly alternate idx 0/1; data matches input order; no loss or duplication.

Source files
------------

// File: rtl/tuple_field_serializer_if.sv
// Tuple-in / field-beat-out bundle for tuple_field_serializer.
// Optional macro TUPLE_SER_COUNT_EN adds the O_count completed-tuple counter.
interface tuple_field_serializer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] I__0;
    logic [WIDTH-1:0] I__1;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O_data;
    logic             O_idx;
    logic             O_last;
    logic             O_valid;
    logic             O_ready;
`ifdef TUPLE_SER_COUNT_EN
    logic [15:0]      O_count;

    modport master (
        output I__0, I__1, I_valid, O_ready,
        input  I_ready, O_data, O_idx, O_last, O_valid, O_count
    );
    modport slave (
        input  I__0, I__1, I_valid, O_ready,
        output I_ready, O_data, O_idx, O_last, O_valid, O_count
    );
`else
    modport master (
        output I__0, I__1, I_valid, O_ready,
        input  I_ready, O_data, O_idx, O_last, O_valid
    );
    modport slave (
        input  I__0, I__1, I_valid, O_ready,
        output I_ready, O_data, O_idx, O_last, O_valid
    );
`endif
endinterface

// File: rtl/tuple_field_serializer.sv
// tuple_field_serializer: buffers {I__1,I__0} tuples in a DEPTH-entry FIFO and
// emits each one as two ordered field beats (field 0, then field 1).
// Optional macro TUPLE_SER_COUNT_EN: O_count counts tuples fully emitted.
module tuple_field_serializer #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESETN,
    tuple_field_serializer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, F0, F1} state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          occ_reg;
    logic                 ready_en_reg;
    logic [2*WIDTH-1:0]   hold_reg;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 in_ready;
    logic                 push;
    logic                 pop;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_idx;
    logic                 out_last;

    // Input readiness comes only from registered occupancy, never from O_ready,
    // so a full FIFO refuses input even in the cycle it is popped.
    assign fifo_empty = (occ_reg == '0);
    assign fifo_full  = (occ_reg == OCC_FULL);
    assign in_ready   = ready_en_reg && !fifo_full;
    assign push       = bus.I_valid && in_ready;

    assign bus.I_ready = in_ready;
    assign bus.O_valid = out_valid;
    assign bus.O_data  = out_data;
    assign bus.O_idx   = out_idx;
    assign bus.O_last  = out_last;

    // FIFO storage write port; the read side is registered through hold_reg.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.I__1, bus.I__0};
        end
    end

    // Pointers, occupancy and the post-reset ready enable.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // Hold register: the tuple currently being serialized, loaded on each pop.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            hold_reg <= '0;
        end else if (pop) begin
            hold_reg <= mem[rd_ptr_reg];
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and pop decision; F1 pops the next tuple directly for no bubble.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = F0;
                end
            end
            F0: begin
                if (bus.O_ready) begin
                    state_next = F1;
                end
            end
            F1: begin
                if (bus.O_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = F0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat outputs decoded from registered state and hold; stable while stalled.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = 1'b0;
        out_last  = 1'b0;
        case (state_reg)
            F0: begin
                out_valid = 1'b1;
                out_data  = hold_reg[WIDTH-1:0];
            end
            F1: begin
                out_valid = 1'b1;
                out_data  = hold_reg[2*WIDTH-1:WIDTH];
                out_idx   = 1'b1;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef TUPLE_SER_COUNT_EN
    logic [15:0] count_reg;

    assign bus.O_count = count_reg;

    // Completed-tuple counter: one step per accepted field-1 beat, wraps at 16 bits.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count_reg <= '0;
        end else if ((state_reg == F1) && bus.O_ready) begin
            count_reg <= count_reg + 16'd1;
        end
    end
`endif

endmodule
